// File: rtl/dbg_pkg.sv
// Shared types and constants for the run-control / state-dump unit.
// Holds the FSM encoding, command bytes and frame-length helper.
package dbg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_MADDR,
        S_MWAIT,
        S_MLATCH,
        S_HALT
    } state_t;

    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;

    // PC (2) + cycle counter (4) + 32 registers (128)
    localparam int unsigned HDR_BYTES = 134;

    function automatic int unsigned frame_len(input int unsigned words);
        return HDR_BYTES + 4 * words;
    endfunction

endpackage

// File: rtl/dbg_byte_sel.sv
// Picks the frame byte at i_idx from the PC / cycle / register / memory fields.
// Ports: i_idx byte index, i_pc, i_cyc, i_regs, i_word snapshot sources; o_byte.
module dbg_byte_sel
    import dbg_pkg::*;
(
    input  logic [10:0]   i_idx,
    input  logic [8:0]    i_pc,
    input  logic [31:0]   i_cyc,
    input  logic [1023:0] i_regs,
    input  logic [31:0]   i_word,
    output logic [7:0]    o_byte
);

    localparam logic [10:0] HDR = 11'(HDR_BYTES);

    logic [15:0] w_pc16;
    logic [1:0]  w_b;
    logic [4:0]  w_reg;
    logic [4:0]  w_lane;
    logic [9:0]  w_reg_bit;

    assign w_pc16 = {7'b0, i_pc};

    // Every 32-bit field starts at an index that is 2 mod 4, so the
    // byte-within-word is idx-2 for cycle, register and memory fields.
    assign w_b    = i_idx[1:0] - 2'd2;
    assign w_reg  = 5'((i_idx[6:0] - 7'd6) >> 2);

    // MSB-first: byte b of a word sits at bit 8*(3-b)
    assign w_lane    = {~w_b, 3'b000};
    assign w_reg_bit = {w_reg, ~w_b, 3'b000};

    always_comb begin
        o_byte = 8'h00;
        unique case (1'b1)
            (i_idx < 11'd2):
                o_byte = i_idx[0] ? w_pc16[7:0] : w_pc16[15:8];
            (i_idx >= 11'd2 && i_idx < 11'd6):
                o_byte = i_cyc[w_lane +: 8];
            (i_idx >= 11'd6 && i_idx < HDR):
                o_byte = i_regs[w_reg_bit +: 8];
            default:
                o_byte = i_word[w_lane +: 8];
        endcase
    end

endmodule

// File: rtl/debug_unit.sv
// Run/step control of the pipeline and byte-serial snapshot dump to the UART.
// Ports: rx_* command in, tx_* byte out, activo/mem_in/mem_write_in/add_in to pipe,
// PCF_o/regs_flat/finalW_o/ReadDataM_o state from pipe, halted status.
module debug_unit
    import dbg_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 16,
    parameter logic [11:0] MEM_BASE  = 12'h000
) (
    input  logic          clk,
    input  logic          inicio_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_done,
    output logic          activo,
    output logic          mem_in,
    output logic          mem_write_in,
    output logic [11:0]   add_in,
    input  logic [8:0]    PCF_o,
    input  logic [1023:0] regs_flat,
    input  logic          finalW_o,
    input  logic [31:0]   ReadDataM_o,
    output logic          halted
);

    localparam logic [10:0] LAST_IDX = 11'(frame_len(MEM_WORDS) - 1);
    localparam logic [10:0] HDR      = 11'(HDR_BYTES);

    state_t      r_state;
    state_t      w_next;
    logic [10:0] r_idx;
    logic [8:0]  r_pc;
    logic [31:0] r_cyc;
    logic [31:0] r_cyc_snap;
    logic [31:0] r_word_buf;
    logic [7:0]  r_tx_data;
    logic        r_tx_start;
    logic [11:0] r_add_in;
    logic        r_halted;

    logic        w_cmd_run;
    logic        w_cmd_step;
    logic        w_cmd_dump;
    logic        w_activo;
    logic        w_in_dump;
    logic        w_entry;
    logic        w_done;
    logic        w_last;
    logic        w_nxt_mem;
    logic [10:0] w_idx_nxt;
    logic [10:0] w_rel;
    logic [31:0] w_cyc_nxt;
    logic [7:0]  w_byte;

    assign w_cmd_run  = rx_valid && (rx_data == CMD_RUN);
    assign w_cmd_step = rx_valid && (rx_data == CMD_STEP);
    assign w_cmd_dump = rx_valid && (rx_data == CMD_DUMP);

    // tx_done in the same cycle as our own tx_start cannot belong to it
    assign w_done    = tx_done && !r_tx_start;
    assign w_last    = (r_idx == LAST_IDX);
    assign w_idx_nxt = r_idx + 11'd1;
    // next byte opens a memory word: fetch it before loading
    assign w_nxt_mem = (w_idx_nxt >= HDR) && (w_idx_nxt[1:0] == HDR[1:0]);
    assign w_rel     = r_idx - HDR;
    assign w_cyc_nxt = r_cyc + {31'b0, w_activo};
    assign w_entry   = !w_in_dump && (w_next == S_LOAD);

    always_ff @(posedge clk or negedge inicio_n) begin
        if (!inicio_n) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_cmd_run)       w_next = S_RUN;
                else if (w_cmd_step) w_next = S_STEP;
                else if (w_cmd_dump) w_next = S_LOAD;
            end
            S_RUN:    if (finalW_o) w_next = S_LOAD;
            S_STEP:   w_next = S_LOAD;
            S_LOAD:   w_next = S_SEND;
            S_SEND:   w_next = S_WAIT;
            S_WAIT: begin
                if (w_done) begin
                    if (w_last)         w_next = r_halted ? S_HALT : S_IDLE;
                    else if (w_nxt_mem) w_next = S_MADDR;
                    else                w_next = S_LOAD;
                end
            end
            S_MADDR:  w_next = S_MWAIT;
            S_MWAIT:  w_next = S_MLATCH;
            S_MLATCH: w_next = S_LOAD;
            S_HALT:   if (w_cmd_dump) w_next = S_LOAD;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_activo  = 1'b0;
        w_in_dump = 1'b0;
        unique case (r_state)
            S_RUN, S_STEP: w_activo = 1'b1;
            S_LOAD, S_SEND, S_WAIT,
            S_MADDR, S_MWAIT, S_MLATCH: w_in_dump = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge inicio_n) begin
        if (!inicio_n) begin
            r_idx      <= '0;
            r_pc       <= '0;
            r_cyc      <= '0;
            r_cyc_snap <= '0;
            r_word_buf <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_add_in   <= '0;
            r_halted   <= 1'b0;
        end else begin
            r_cyc      <= w_cyc_nxt;
            // data goes out in LOAD, the strobe follows a cycle later
            r_tx_start <= (r_state == S_SEND);
            if (w_activo && finalW_o) r_halted <= 1'b1;
            if (w_entry) begin
                r_pc       <= PCF_o;
                r_cyc_snap <= w_cyc_nxt;
                r_idx      <= '0;
            end
            if (r_state == S_LOAD) r_tx_data <= w_byte;
            if (r_state == S_WAIT && w_done && !w_last) r_idx <= w_idx_nxt;
            if (r_state == S_MADDR) r_add_in <= MEM_BASE + 12'(w_rel >> 2);
            if (r_state == S_MLATCH) r_word_buf <= ReadDataM_o;
        end
    end

    dbg_byte_sel u_sel (
        .i_idx  (r_idx),
        .i_pc   (r_pc),
        .i_cyc  (r_cyc_snap),
        .i_regs (regs_flat),
        .i_word (r_word_buf),
        .o_byte (w_byte)
    );

    assign tx_data      = r_tx_data;
    assign tx_start     = r_tx_start;
    assign activo       = w_activo;
    assign mem_in       = w_in_dump;
    assign mem_write_in = w_in_dump;
    assign add_in       = r_add_in;
    assign halted       = r_halted;

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: UART and data-memory models, frame model.
// Table of frame-byte vectors plus hand-written run/halt/reset sequences.
module tb_debug_unit;
    import dbg_pkg::*;

    localparam int unsigned MW   = 16;
    localparam logic [11:0] MB   = 12'h010;
    localparam int          FLEN = 134 + 4 * MW;

    logic          clk = 1'b0;
    logic          inicio_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_done = 1'b0;
    logic          activo;
    logic          mem_in;
    logic          mem_write_in;
    logic [11:0]   add_in;
    logic [8:0]    PCF_o = 9'h000;
    logic [1023:0] regs_flat;
    logic          finalW_o = 1'b0;
    logic [31:0]   ReadDataM_o = 32'h0;
    logic          halted;

    always #5 clk = ~clk;

    debug_unit #(.MEM_WORDS(MW), .MEM_BASE(MB)) dut (
        .clk          (clk),
        .inicio_n     (inicio_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_done      (tx_done),
        .activo       (activo),
        .mem_in       (mem_in),
        .mem_write_in (mem_write_in),
        .add_in       (add_in),
        .PCF_o        (PCF_o),
        .regs_flat    (regs_flat),
        .finalW_o     (finalW_o),
        .ReadDataM_o  (ReadDataM_o),
        .halted       (halted)
    );

    logic [31:0] regs [32];
    always_comb begin
        regs_flat = '0;
        for (int k = 0; k < 32; k++) regs_flat[32*k +: 32] = regs[k];
    end

    // data memory: word at address a holds 0x1000 + a, one-cycle read
    always @(posedge clk) ReadDataM_o <= 32'h1000 + {20'h0, add_in};

    int          n_vec = 0;
    int          n_err = 0;
    int          n_ovl = 0;
    int          n_rst_tx = 0;
    int          n_flag = 0;
    int          n_act = 0;
    int          max_dly = 0;
    int          dly_cnt = 0;
    bit          busy = 0;
    logic [7:0]  cap [$];
    logic [11:0] add_log [$];
    logic [11:0] prev_add = 12'h0;

    // UART transmitter model
    always @(negedge clk) begin
        if (!inicio_n) begin
            if (tx_start) n_rst_tx++;
            busy    = 0;
            tx_done = 1'b0;
        end else begin
            if (tx_done) begin
                tx_done = 1'b0;
                busy    = 0;
            end
            if (tx_start) begin
                if (busy) n_ovl++;
                cap.push_back(tx_data);
                busy    = 1;
                dly_cnt = int'($urandom_range(max_dly, 0));
            end else if (busy) begin
                if (dly_cnt == 0) tx_done = 1'b1;
                else dly_cnt--;
            end
        end
    end

    always @(negedge clk) begin
        if (activo) n_act++;
        if (inicio_n) begin
            if (mem_in !== mem_write_in) n_flag++;
            if (activo && mem_in) n_flag++;
            if (tx_start && !mem_in) n_flag++;
        end
        if (mem_in && add_in != prev_add) add_log.push_back(add_in);
        prev_add = add_in;
    end

    typedef struct {
        int         idx;
        logic [7:0] exp;
        string      nm;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] cap_at(input int i);
        if (i < cap.size()) return {1'b0, cap[i]};
        return 9'h1FF;
    endfunction

    function automatic logic [7:0] exp_byte(input int i, input logic [8:0] pc,
                                            input logic [31:0] cyc);
        logic [15:0] p;
        logic [31:0] w;
        p = {7'b0, pc};
        if (i == 0) return p[15:8];
        if (i == 1) return p[7:0];
        if (i < 6) return cyc[8*(5-i) +: 8];
        if (i < 134) w = regs[(i-6)/4];
        else w = 32'h1000 + {20'h0, MB + 12'((i-134)/4)};
        return w[8*(3-((i-6)%4)) +: 8];
    endfunction

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic clear_logs();
        cap.delete();
        add_log.delete();
        n_act = 0;
    endtask

    task automatic check_frame(input string nm, input logic [8:0] pc,
                               input logic [31:0] cyc);
        int t = 0;
        int bad = 0;
        int abad = 0;
        int first = -1;
        while ((cap.size() < FLEN || mem_in) && t < 8000) begin
            @(negedge clk);
            t++;
        end
        chk({nm, " frame done"}, 64'(t < 8000), 64'd1);
        repeat (30) @(negedge clk);
        chk({nm, " length"}, 64'(cap.size()), 64'(FLEN));
        for (int i = 0; i < cap.size() && i < FLEN; i++) begin
            if (cap[i] !== exp_byte(i, pc, cyc)) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        if (first >= 0)
            $display("  %s first differing byte %0d: %02h vs %02h", nm,
                     first, cap[first], exp_byte(first, pc, cyc));
        chk({nm, " bad bytes"}, 64'(bad), 64'd0);
        if (add_log.size() != MW) abad++;
        for (int i = 0; i < add_log.size(); i++)
            if (add_log[i] !== MB + 12'(i)) abad++;
        chk({nm, " add_in sequence"}, 64'(abad), 64'd0);
        chk({nm, " idle outputs"},
            64'({mem_in, mem_write_in, activo, tx_start}), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 inicio_n = 1'b0;
        #1 chk("reset outputs",
               64'({tx_data, tx_start, activo, mem_in, mem_write_in,
                    add_in, halted}), 64'd0);
        repeat (3) @(negedge clk);
        #2 inicio_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n0;
        logic [7:0] kb;

        tbl.push_back('{0,   8'h00, "pc hi"});
        tbl.push_back('{1,   8'h04, "pc lo"});
        tbl.push_back('{2,   8'h00, "cyc b3"});
        tbl.push_back('{3,   8'h00, "cyc b2"});
        tbl.push_back('{4,   8'h00, "cyc b1"});
        tbl.push_back('{5,   8'h01, "cyc b0"});
        tbl.push_back('{6,   8'h00, "r0 b3"});
        tbl.push_back('{7,   8'h5A, "r0 b2"});
        tbl.push_back('{8,   8'hFF, "r0 b1"});
        tbl.push_back('{9,   8'h30, "r0 b0"});
        tbl.push_back('{26,  8'hDE, "r5 b3"});
        tbl.push_back('{27,  8'hAD, "r5 b2"});
        tbl.push_back('{28,  8'hBE, "r5 b1"});
        tbl.push_back('{29,  8'hEF, "r5 b0"});
        tbl.push_back('{133, 8'h4F, "r31 b0"});
        tbl.push_back('{134, 8'h00, "mem0 b3"});
        tbl.push_back('{136, 8'h10, "mem0 b1"});
        tbl.push_back('{137, 8'h10, "mem0 b0"});
        tbl.push_back('{194, 8'h00, "memlast b3"});
        tbl.push_back('{195, 8'h00, "memlast b2"});
        tbl.push_back('{196, 8'h10, "memlast b1"});
        tbl.push_back('{197, 8'h1F, "memlast b0"});

        for (int k = 0; k < 32; k++) begin
            kb = 8'(k);
            regs[k] = {kb, kb ^ 8'h5A, ~kb, kb + 8'h30};
        end
        regs[5] = 32'hDEADBEEF;

        // power-on reset
        repeat (3) @(negedge clk);
        chk("rst tx_start", 64'(tx_start), 64'd0);
        chk("rst activo", 64'(activo), 64'd0);
        chk("rst halted", 64'(halted), 64'd0);
        chk("rst add_in", 64'(add_in), 64'd0);
        chk("rst mem_in", 64'({mem_in, mem_write_in}), 64'd0);
        #2 inicio_n = 1'b1;

        // unknown byte is ignored, then single step
        PCF_o = 9'h004;
        clear_logs();
        send_cmd(8'h41);
        repeat (5) @(negedge clk);
        chk("junk byte ignored", 64'({activo, mem_in, tx_start}), 64'd0);
        send_cmd(CMD_STEP);
        chk("step latency", 64'(activo), 64'd1);
        check_frame("step", 9'h004, 32'd1);
        chk("step activo cycles", 64'(n_act), 64'd1);
        chk("step halted", 64'(halted), 64'd0);
        foreach (tbl[i])
            chk(tbl[i].nm, 64'(cap_at(tbl[i].idx)), 64'(tbl[i].exp));

        // run until program end, then halt behaviour
        do_reset();
        PCF_o = 9'h1A5;
        clear_logs();
        send_cmd(CMD_RUN);
        chk("run latency", 64'(activo), 64'd1);
        repeat (50) @(negedge clk);
        finalW_o = 1'b1;
        @(negedge clk);
        finalW_o = 1'b0;
        chk("run stops", 64'(activo), 64'd0);
        chk("halted set", 64'(halted), 64'd1);
        check_frame("run", 9'h1A5, 32'h33);
        chk("run activo cycles", 64'(n_act), 64'd51);
        chk("run cyc bytes",
            64'({cap_at(2), cap_at(3), cap_at(4), cap_at(5)}),
            64'({9'h000, 9'h000, 9'h000, 9'h033}));
        chk("run pc bytes", 64'({cap_at(0), cap_at(1)}),
            64'({9'h001, 9'h0A5}));
        clear_logs();
        send_cmd(CMD_STEP);
        repeat (20) @(negedge clk);
        chk("step in halt activo", 64'(n_act), 64'd0);
        chk("step in halt bytes", 64'(cap.size()), 64'd0);
        send_cmd(CMD_DUMP);
        check_frame("halt dump", 9'h1A5, 32'h33);
        chk("still halted", 64'(halted), 64'd1);

        // slow UART, run command while dumping
        do_reset();
        PCF_o   = 9'h0F0;
        max_dly = 20;
        clear_logs();
        send_cmd(CMD_DUMP);
        t = 0;
        while (cap.size() < 40 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("reach byte 40", 64'(cap.size() >= 40), 64'd1);
        send_cmd(CMD_RUN);
        chk("c mid-dump ignored", 64'(activo), 64'd0);
        check_frame("slow", 9'h0F0, 32'd0);
        chk("slow activo cycles", 64'(n_act), 64'd0);
        chk("no overlap", 64'(n_ovl), 64'd0);
        max_dly = 0;

        // reset in the middle of a frame
        do_reset();
        PCF_o = 9'h077;
        clear_logs();
        send_cmd(CMD_STEP);
        t = 0;
        while (cap.size() < 70 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("reach byte 70", 64'(cap.size() >= 70), 64'd1);
        @(negedge clk);
        #2 inicio_n = 1'b0;
        #1 chk("mid-frame reset outputs",
               64'({tx_data, tx_start, activo, mem_in, mem_write_in,
                    add_in, halted}), 64'd0);
        n0 = cap.size();
        repeat (3) @(negedge clk);
        #2 inicio_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no bytes after reset", 64'(cap.size()), 64'(n0));
        chk("no tx_start in reset", 64'(n_rst_tx), 64'd0);
        clear_logs();
        send_cmd(CMD_DUMP);
        check_frame("post reset", 9'h077, 32'd0);
        chk("post reset cyc", 64'({cap_at(4), cap_at(5)}), 64'd0);

        chk("overlap total", 64'(n_ovl), 64'd0);
        chk("mem flag errors", 64'(n_flag), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/debug_unit.md
# debug_unit

Run-control and state-dump controller sitting directly downstream of the `Pipe` pipeline top and upstream of the UART. It decodes command bytes from the UART receiver and gates the pipeline through `activo` for continuous run or single step. After each run or step it serialises a snapshot to the UART transmitter, one byte per handshake. The snapshot is PC, an active-cycle counter, the 32 architectural registers and a window of data memory, which is read through the pipeline's `mem_in`/`add_in` debug port.

## Interface
Parameters:
- MEM_WORDS, 16: data-memory words dumped per frame (1..256).
- MEM_BASE, 12'h000: first word address dumped.

Ports:
- clk  in  1  system clock.
- inicio_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle pulse: rx_data is valid.
- tx_data  out  8  byte to transmit; reset 0.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data; reset 0.
- tx_done  in  1  one-cycle pulse: UART finished the current byte.
- activo  out  1  pipeline advance enable; reset 0.
- mem_in  out  1  steers data-memory address to add_in; reset 0.
- mem_write_in  out  1  suppresses pipeline memory writes; reset 0.
- add_in  out  12  debug data-memory address; reset 0.
- PCF_o  in  9  fetch PC.
- regs_flat  in  1024  register bank; register k occupies bits [32k+31:32k].
- finalW_o  in  1  program-end marker at write-back.
- ReadDataM_o  in  32  data-memory read port; valid one cycle after add_in changes.
- halted  out  1  program has ended; reset 0.

## Operation
- Commands are accepted only in IDLE or HALT. Any rx_valid in another state is dropped.
  - 0x63 'c': run. Accepted in IDLE only.
  - 0x73 's': single step. Accepted in IDLE only.
  - 0x64 'd': dump without running. Accepted in IDLE or HALT.
  - Any other byte is ignored.
- States and transitions:
  - IDLE → RUN ('c'), STEP ('s'), DUMP ('d').
  - RUN: activo=1. When finalW_o is sampled 1, set halted; activo=0 from the next edge; go to DUMP.
  - STEP: activo=1 for exactly one clock, then DUMP. If finalW_o is 1 during that cycle, set halted.
  - DUMP → IDLE when the frame completes and halted=0; → HALT when halted=1.
  - HALT: only 'd' or reset leaves it.
- Frame byte order, each field MSB-first:
  - Bytes 0-1: {7'b0, PCF_o}.
  - Bytes 2-5: cyc_cnt.
  - Bytes 6-133: registers 0..31.
  - Then 4×MEM_WORDS bytes: words MEM_BASE..MEM_BASE+MEM_WORDS-1.
  - Frame length = 134 + 4·MEM_WORDS bytes.
- Snapshot capture:
  - PC and cyc_cnt are latched on DUMP entry.
  - Registers are read live; they are stable because activo=0.
- cyc_cnt: 32-bit, +1 on every clock with activo=1, wraps 0xFFFFFFFF→0. Reset to 0 only by inicio_n.
- Memory fetch sub-sequence, once per word:
  - MEM_ADDR: drive add_in.
  - MEM_WAIT: one cycle.
  - MEM_LATCH: capture ReadDataM_o into word_buf.
  - Then send the 4 bytes of word_buf.
- mem_in and mem_write_in are both 1 throughout DUMP, 0 elsewhere.
- add_in wraps modulo 4096 if MEM_BASE+k overflows.

## Timing
- tx_start:
  - Pulses one cycle after tx_data is set.
  - At most one outstanding byte; the next tx_start may not come before the cycle after tx_done.
  - tx_done pulses while not waiting are ignored.
- Command latency: rx_valid at edge t → activo=1 from edge t+1.
- activo in RUN stays 1 through the edge at which finalW_o is sampled, so the pipeline advances once more.
- Memory read: add_in is set at edge n; ReadDataM_o is sampled at edge n+2.
- Simultaneous events:
  - rx_valid together with the final tx_done of a frame: the byte is dropped.
  - finalW_o in STEP: halted is set and the frame is still sent.
- inicio_n low at any time, including mid-byte or mid-RUN:
  - All outputs and state return to reset values immediately.
  - The byte in flight is abandoned; no tx_start is issued while reset is asserted.

## Structure
- Package dbg_pkg holds:
  - State enum.
  - Command constants CMD_RUN/CMD_STEP/CMD_DUMP.
  - HDR_BYTES=134.
  - A frame-length function of MEM_WORDS.
- Sub-module dbg_byte_sel: combinational selection of the frame byte from {pc, cyc_cnt, regs_flat, word_buf} given byte index.
- FSM, counters and handshake live in debug_unit.

## Test plan
- Reset, then 's' with PCF_o=0x004: activo high exactly 1 cycle; frame starts 0x00,0x04,0x00,0x00,0x00,0x01; length 198 bytes at MEM_WORDS=16.
- Reset, 'c', finalW_o raised after 50 cycles: cyc_cnt bytes = 0x00000033; halted=1; a following 's' produces no activo, and 'd' produces a frame.
- Register 5=0xDEADBEEF: frame bytes 26-29 = DE AD BE EF.
- Memory model with word k = 0x1000+k, MEM_BASE=0x010:
  - add_in steps 0x010..0x01F.
  - Last 4 bytes = 00 00 10 1F.
  - mem_in and mem_write_in are 1 only during DUMP.
- tx_done delayed 0-20 random cycles: no tx_start overlaps; 'c' sent mid-dump is ignored.
- inicio_n pulsed low at byte 70: all outputs are 0; a later 'd' restarts the frame at byte 0 with cyc_cnt=0.
